mc_ctrl_hs: RTL and testbench
=============================

Name: mc_ctrl_hs

Overview:
- Next-generation multicycle MIPS-lite control FSM: FETCH/DCD/EXE/MA/WB with req/ack memory handshakes, so memories may take a variable number of cycles.
- Adds a bounded ack timeout, illegal-opcode detection, latched addi overflow trap to $30, and a fully defaulted (latch-free) output decoder.
- Sits between the IR opcode/funct fields and the datapath muxes/write enables of the multicycle core.

Parameters:
- ACK_TIMEOUT, 16: cycles a req waits for ack before timeout; 0 = wait forever.
- TO_W, 5: timeout counter width; must hold ACK_TIMEOUT.
- CNT_W, 32: retired-instruction counter width (optional feature only).

Ports:
- clk in 1: clock
- rst in 1: reset, asynchronous, active-low
- op in 6: IR[31:26]
- funct in 6: IR[5:0]
- zero in 1: ALU zero
- overflow in 1: ALU signed overflow
- imem_req out 1: instruction fetch request
- imem_ack in 1: instruction valid this cycle
- dmem_req out 1: data access request
- dmem_ack in 1: data access complete
- PCWr, IRWr, DMWr, GPRWr, ALUsrc, ALUsign, byteOp out 1 each: datapath strobes/selects
- ALUop out 2: 00 add, 01 sub, 10 or, 11 slt
- ExtOp out 2: 00 zero, 01 sign, 10 lui
- NPCop out 2: 00 pc+4, 01 beq, 10 j/jal, 11 jr
- M2Rsel out 2: 00 ALU, 01 DM, 10 link pc+4, 11 const 1
- GPRsel out 2: 00 rd, 01 rt, 10 $31, 11 $30
- state_o out 3: current state
- illegal out 1: one-cycle pulse on unknown instruction
- bus_err out 1: sticky; set on data timeout

Behaviour:
- States: IDLE=7, FETCH=0, DCD=1, EXE=2, MA=3, WB=4.
- Reset: state IDLE, ovf_q=0, bus_err=0, timeout count 0.
- IDLE: next cycle always FETCH.
- Output defaults: every output 0 in every state unless listed below; no latches.
- FETCH: imem_req=1.
  - imem_ack=1: PCWr=1, IRWr=1, NPCop=00, go DCD.
  - No ack: hold FETCH.
  - Timeout: drop req for one cycle, counter cleared, then retry. Never sets bus_err.
- DCD: ExtOp[0]=lw|lb|sw|sb|addi; ExtOp[1]=lui.
  - jal -> WB.
  - Unknown op/funct -> illegal=1, go FETCH, no writes.
  - Otherwise -> EXE.
- EXE:
  - ALUsrc=ori|lw|lb|sw|sb|lui|addi|addiu.
  - ALUop[0]=subu|beq|slt; ALUop[1]=ori|slt.
  - ALUsign=addi|slt.
  - NPCop per encoding.
  - PCWr=j|jr|(beq&zero).
  - ovf_q <= addi&overflow.
  - Next: beq/j/jr -> FETCH; loads/stores -> MA; other ALU ops -> WB.
- MA: dmem_req=1, byteOp=lb|sb, DMWr=(sw|sb)&dmem_ack.
  - Ack: loads -> WB, stores -> FETCH.
  - Timeout: bus_err<=1, no write, go FETCH.
- WB:
  - GPRWr=1 for addu/subu/slt/ori/addi/addiu/lw/lb/lui/jal.
  - M2Rsel: lw|lb -> 01; jal -> 10; ovf_q -> 11; else 00.
  - GPRsel: rt for I-type ALU ops and loads; $31 for jal; $30 when ovf_q; else rd.
  - jal: PCWr=1, NPCop=10.
  - Next: FETCH. ovf_q cleared on leaving WB.
- Timeout counter: cleared on entering FETCH/MA and on each ack. Timeout fires when count==ACK_TIMEOUT-1 with ack still low.
- Ack arriving in the same cycle as a new req is legal and accepted.
- Ack outside a req cycle is ignored.
- Reset mid-access: async to IDLE, req deasserted immediately.

Optional Feature:
- Macro RETIRE_CNT_EN.
- Defined: adds output retired[CNT_W-1:0]. Increments on each transition back to FETCH from EXE, MA or WB, excluding illegal and timeout exits. Resets to 0 and wraps modulo 2^CNT_W.
- Undefined: port and counter absent.

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode/funct constants
  - state encodings
  - ALUop/ExtOp/NPCop/M2Rsel/GPRsel encodings
- Sub-module mc_ctrl_dec: pure combinational op/funct -> one-hot instruction flags plus illegal. The FSM instantiates it once.

Test Plan:
- Reset, then imem_ack after 3 cycles with addu -> FETCH held 3 cycles. PCWr/IRWr high only in ack cycle. WB: GPRWr=1, GPRsel=00, M2Rsel=00.
- lw with dmem_ack after 2 wait cycles -> MA held. WB: M2Rsel=01, GPRsel=01. Total 7 cycles from fetch ack.
- beq with zero=1 -> EXE: PCWr=1, NPCop=01. With zero=0 -> PCWr=0. Both return to FETCH after EXE.
- addi 0x7FFFFFFF+1 with overflow=1 -> WB: GPRsel=11, M2Rsel=11, GPRWr=1.
- sw with dmem_ack never arriving, ACK_TIMEOUT=16 -> 16 MA cycles. DMWr never 1. bus_err=1 sticky, then FETCH.
- op=6'b111111 -> illegal pulse one cycle in DCD. No PCWr/GPRWr/DMWr. Next state FETCH.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multicycle MIPS-lite control FSM:
// opcode/funct values, state encodings, mux-select encodings and
// the one-hot instruction flag struct produced by the decoder.
package mc_ctrl_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    // FSM states; IDLE sits apart so a reset state is easy to spot on state_o
    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_DCD   = 3'd1,
        ST_EXE   = 3'd2,
        ST_MA    = 3'd3,
        ST_WB    = 3'd4,
        ST_IDLE  = 3'd7
    } state_e;

    // ALUop
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_SLT = 2'b11;

    // ExtOp
    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    // NPCop
    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_BEQ = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    // M2Rsel
    localparam logic [1:0] M2R_ALU  = 2'b00;
    localparam logic [1:0] M2R_DM   = 2'b01;
    localparam logic [1:0] M2R_LINK = 2'b10;
    localparam logic [1:0] M2R_ONE  = 2'b11;

    // GPRsel
    localparam logic [1:0] GPR_RD  = 2'b00;
    localparam logic [1:0] GPR_RT  = 2'b01;
    localparam logic [1:0] GPR_31  = 2'b10;
    localparam logic [1:0] GPR_30  = 2'b11;

    // One-hot instruction flags; at most one bit set for a legal instruction
    typedef struct packed {
        logic addu;
        logic subu;
        logic slt;
        logic jr;
        logic ori;
        logic lw;
        logic lb;
        logic sw;
        logic sb;
        logic lui;
        logic addi;
        logic addiu;
        logic beq;
        logic j;
        logic jal;
    } instr_t;

endpackage

// File: rtl/mc_ctrl_dec.sv
// Pure combinational instruction decoder: op/funct -> one-hot
// instruction flags, plus an illegal flag for anything unrecognised.
module mc_ctrl_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output instr_t     ins,
    output logic       illegal
);

    // Decode the opcode, falling through to funct for R-type
    always_comb begin
        ins     = '0;
        illegal = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: ins.addu = 1'b1;
                    FN_SUBU: ins.subu = 1'b1;
                    FN_SLT:  ins.slt  = 1'b1;
                    FN_JR:   ins.jr   = 1'b1;
                    default: illegal  = 1'b1;
                endcase
            end
            OP_J:     ins.j     = 1'b1;
            OP_JAL:   ins.jal   = 1'b1;
            OP_BEQ:   ins.beq   = 1'b1;
            OP_ADDI:  ins.addi  = 1'b1;
            OP_ADDIU: ins.addiu = 1'b1;
            OP_ORI:   ins.ori   = 1'b1;
            OP_LUI:   ins.lui   = 1'b1;
            OP_LB:    ins.lb    = 1'b1;
            OP_LW:    ins.lw    = 1'b1;
            OP_SB:    ins.sb    = 1'b1;
            OP_SW:    ins.sw    = 1'b1;
            default:  illegal   = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_hs.sv
// Multicycle MIPS-lite control FSM with req/ack memory handshakes.
// Handshake: a req is held high while waiting; an ack seen in a cycle
// where req is high completes the access in that same cycle (an ack in
// the very first req cycle is fine); an ack while req is low is ignored.
// A req that sees no ack for ACK_TIMEOUT cycles times out (0 = never).
// Optional feature: define RETIRE_CNT_EN to add the `retired` counter.
module mc_ctrl_hs
    import mc_ctrl_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int TO_W        = 5
`ifdef RETIRE_CNT_EN
    ,
    parameter int CNT_W       = 32
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic       imem_req,
    input  logic       imem_ack,
    output logic       dmem_req,
    input  logic       dmem_ack,
    output logic       PCWr,
    output logic       IRWr,
    output logic       DMWr,
    output logic       GPRWr,
    output logic       ALUsrc,
    output logic       ALUsign,
    output logic       byteOp,
    output logic [1:0] ALUop,
    output logic [1:0] ExtOp,
    output logic [1:0] NPCop,
    output logic [1:0] M2Rsel,
    output logic [1:0] GPRsel,
    output logic [2:0] state_o,
    output logic       illegal,
    output logic       bus_err
`ifdef RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] retired
`endif
);

    state_e          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            bus_err_q, bus_err_d;
    logic            drop_q, drop_d;

    instr_t ins;
    logic   dec_illegal;

    logic in_wait;
    logic ack_sel;
    logic req_ack;
    logic timeout;

    mc_ctrl_dec u_dec (
        .op      (op),
        .funct   (funct),
        .ins     (ins),
        .illegal (dec_illegal)
    );

    // Handshake bookkeeping: which req is live, whether it completed or expired
    always_comb begin
        in_wait = ((state_q == ST_FETCH) && !drop_q) || (state_q == ST_MA);
        ack_sel = (state_q == ST_FETCH) ? imem_ack : dmem_ack;
        req_ack = in_wait && ack_sel;
        timeout = (ACK_TIMEOUT != 0) && in_wait && !ack_sel &&
                  (cnt_q == TO_W'(ACK_TIMEOUT - 1));
        // Count only while a req waits; any exit, ack or expiry restarts at 0
        if (in_wait && !ack_sel && !timeout) cnt_d = cnt_q + TO_W'(1);
        else                                 cnt_d = '0;
        // After a fetch timeout, req drops for exactly one cycle before retry
        drop_d = (state_q == ST_FETCH) && timeout;
    end

    // Next-state, overflow latch and sticky bus error
    always_comb begin
        state_d   = state_q;
        ovf_d     = ovf_q;
        bus_err_d = bus_err_q;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: if (req_ack) state_d = ST_DCD;
            ST_DCD: begin
                if (dec_illegal)  state_d = ST_FETCH;
                else if (ins.jal) state_d = ST_WB;
                else              state_d = ST_EXE;
            end
            ST_EXE: begin
                ovf_d = ins.addi & overflow;
                if (ins.beq | ins.j | ins.jr)              state_d = ST_FETCH;
                else if (ins.lw | ins.lb | ins.sw | ins.sb) state_d = ST_MA;
                else                                        state_d = ST_WB;
            end
            ST_MA: begin
                if (req_ack) begin
                    state_d = (ins.lw | ins.lb) ? ST_WB : ST_FETCH;
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            ST_WB: begin
                ovf_d   = 1'b0;
                state_d = ST_FETCH;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM state and control registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            bus_err_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            bus_err_q <= bus_err_d;
            drop_q    <= drop_d;
        end
    end

    // Output decoder; every output defaults to 0 so nothing latches
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        PCWr     = 1'b0;
        IRWr     = 1'b0;
        DMWr     = 1'b0;
        GPRWr    = 1'b0;
        ALUsrc   = 1'b0;
        ALUsign  = 1'b0;
        byteOp   = 1'b0;
        ALUop    = ALU_ADD;
        ExtOp    = EXT_ZERO;
        NPCop    = NPC_PC4;
        M2Rsel   = M2R_ALU;
        GPRsel   = GPR_RD;
        illegal  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req = !drop_q;
                if (req_ack) begin
                    PCWr = 1'b1;
                    IRWr = 1'b1;
                end
            end
            ST_DCD: begin
                ExtOp   = {ins.lui, ins.lw | ins.lb | ins.sw | ins.sb | ins.addi};
                illegal = dec_illegal;
            end
            ST_EXE: begin
                ALUsrc  = ins.ori | ins.lw | ins.lb | ins.sw | ins.sb |
                          ins.lui | ins.addi | ins.addiu;
                ALUop   = {ins.ori | ins.slt, ins.subu | ins.beq | ins.slt};
                ALUsign = ins.addi | ins.slt;
                if (ins.beq)     NPCop = NPC_BEQ;
                else if (ins.j)  NPCop = NPC_J;
                else if (ins.jr) NPCop = NPC_JR;
                PCWr    = ins.j | ins.jr | (ins.beq & zero);
            end
            ST_MA: begin
                dmem_req = 1'b1;
                byteOp   = ins.lb | ins.sb;
                DMWr     = (ins.sw | ins.sb) & req_ack;
            end
            ST_WB: begin
                GPRWr = ins.addu | ins.subu | ins.slt | ins.ori | ins.addi |
                        ins.addiu | ins.lw | ins.lb | ins.lui | ins.jal;
                if (ins.lw | ins.lb) M2Rsel = M2R_DM;
                else if (ins.jal)    M2Rsel = M2R_LINK;
                else if (ovf_q)      M2Rsel = M2R_ONE;
                if (ins.jal)         GPRsel = GPR_31;
                else if (ovf_q)      GPRsel = GPR_30;
                else if (ins.ori | ins.addi | ins.addiu | ins.lui | ins.lw | ins.lb)
                                     GPRsel = GPR_RT;
                if (ins.jal) begin
                    PCWr  = 1'b1;
                    NPCop = NPC_J;
                end
            end
            default: ;
        endcase
    end

    assign state_o = state_q;
    assign bus_err = bus_err_q;

`ifdef RETIRE_CNT_EN
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire_ev;

    // A retirement is a normal return to FETCH from EXE, MA or WB
    always_comb begin
        retire_ev = (state_d == ST_FETCH) &&
                    ((state_q == ST_EXE) || (state_q == ST_WB) ||
                     ((state_q == ST_MA) && req_ack));
        retired_d = retire_ev ? retired_q + CNT_W'(1) : retired_q;
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) retired_q <= '0;
        else      retired_q <= retired_d;
    end

    assign retired = retired_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Directed bench for mc_ctrl_hs: the driver pushes a hand-written
// expected output snapshot for every cycle it drives; the monitor pops
// and compares on the falling edge.
module tb_mc_ctrl_hs;

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_DCD   = 3'd1;
    localparam logic [2:0] S_EXE   = 3'd2;
    localparam logic [2:0] S_MA    = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;
    localparam logic [2:0] S_IDLE  = 3'd7;

    typedef struct packed {
        logic [2:0] state;
        logic       imem_req;
        logic       dmem_req;
        logic       pcwr;
        logic       irwr;
        logic       dmwr;
        logic       gprwr;
        logic       alusrc;
        logic       alusign;
        logic       byteop;
        logic [1:0] aluop;
        logic [1:0] extop;
        logic [1:0] npcop;
        logic [1:0] m2rsel;
        logic [1:0] gprsel;
        logic       illegal;
        logic       bus_err;
    } exp_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [5:0] op = '0, funct = '0;
    logic       zero = 1'b0, overflow = 1'b0;
    logic       imem_ack = 1'b0, dmem_ack = 1'b0;
    logic       imem_req, dmem_req, PCWr, IRWr, DMWr, GPRWr, ALUsrc, ALUsign, byteOp;
    logic [1:0] ALUop, ExtOp, NPCop, M2Rsel, GPRsel;
    logic [2:0] state_o;
    logic       illegal, bus_err;
`ifdef RETIRE_CNT_EN
    logic [31:0] retired;
`endif

    mc_ctrl_hs #(.ACK_TIMEOUT(16), .TO_W(5)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .overflow(overflow),
        .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .PCWr(PCWr), .IRWr(IRWr), .DMWr(DMWr), .GPRWr(GPRWr), .ALUsrc(ALUsrc),
        .ALUsign(ALUsign), .byteOp(byteOp), .ALUop(ALUop), .ExtOp(ExtOp), .NPCop(NPCop),
        .M2Rsel(M2Rsel), .GPRsel(GPRsel), .state_o(state_o), .illegal(illegal),
        .bus_err(bus_err)
`ifdef RETIRE_CNT_EN
        , .retired(retired)
`endif
    );

    // scoreboard
    logic [$bits(exp_t)-1:0] exp_q[$];
    string                   tag_q[$];
    int errors = 0;
    int checks = 0;
    logic exp_bus_err = 1'b0;

    // pending instruction, loaded onto op/funct at the next fetch
    logic [5:0] p_op, p_funct;
    logic       p_zero, p_ovf;
    logic       load_ir = 1'b0;

    function automatic exp_t f_st(input logic [2:0] s);
        exp_t e;
        e = '0;
        e.state   = s;
        e.bus_err = exp_bus_err;
        return e;
    endfunction

    // driver tasks
    task automatic drive(input logic ia, input logic da, input exp_t e, input string tag);
        @(posedge clk);
        #1;
        if (load_ir) begin
            op = p_op; funct = p_funct; zero = p_zero; overflow = p_ovf;
            load_ir = 1'b0;
        end
        imem_ack = ia;
        dmem_ack = da;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic set_ir(input logic [5:0] o, input logic [5:0] f, input logic z, input logic ov);
        p_op = o; p_funct = f; p_zero = z; p_ovf = ov; load_ir = 1'b1;
    endtask

    task automatic t_fetch(input int waits);
        exp_t e;
        for (int i = 0; i < waits; i++) begin
            e = f_st(S_FETCH); e.imem_req = 1'b1;
            drive(1'b0, 1'b0, e, "fetch_wait");
        end
        e = f_st(S_FETCH); e.imem_req = 1'b1; e.pcwr = 1'b1; e.irwr = 1'b1;
        drive(1'b1, 1'b0, e, "fetch_ack");
    endtask

    task automatic t_dcd(input logic [1:0] ext, input logic ill);
        exp_t e;
        e = f_st(S_DCD); e.extop = ext; e.illegal = ill;
        drive(1'b0, 1'b0, e, "dcd");
    endtask

    task automatic t_exe(input logic src, input logic [1:0] aop, input logic sgn,
                         input logic [1:0] npc, input logic pcw);
        exp_t e;
        e = f_st(S_EXE); e.alusrc = src; e.aluop = aop; e.alusign = sgn;
        e.npcop = npc; e.pcwr = pcw;
        drive(1'b0, 1'b0, e, "exe");
    endtask

    task automatic t_ma(input logic da, input logic bop, input logic dmw);
        exp_t e;
        e = f_st(S_MA); e.dmem_req = 1'b1; e.byteop = bop; e.dmwr = dmw;
        drive(1'b0, da, e, "ma");
    endtask

    task automatic t_wb(input logic gw, input logic [1:0] m2r, input logic [1:0] gsel,
                        input logic pcw, input logic [1:0] npc);
        exp_t e;
        e = f_st(S_WB); e.gprwr = gw; e.m2rsel = m2r; e.gprsel = gsel;
        e.pcwr = pcw; e.npcop = npc;
        drive(1'b0, 1'b0, e, "wb");
    endtask

    // monitor: every driven cycle presents one output snapshot
    always @(negedge clk) begin
        exp_t  act, e;
        string tag;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            tag = tag_q.pop_front();
            act = '{state_o, imem_req, dmem_req, PCWr, IRWr, DMWr, GPRWr, ALUsrc,
                    ALUsign, byteOp, ALUop, ExtOp, NPCop, M2Rsel, GPRsel, illegal, bus_err};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s @%0t: got %b expected %b", tag, $time, act, e);
            end
        end
    end

    // stimulus
    initial begin
        exp_t e;
        // reset held, then released in the IDLE cycle
        drive(1'b0, 1'b0, f_st(S_IDLE), "reset");
        drive(1'b0, 1'b0, f_st(S_IDLE), "idle");
        rst = 1'b1;

        // addu with 3 fetch wait cycles
        set_ir(6'b000000, 6'b100001, 1'b0, 1'b0);
        t_fetch(3); t_dcd(2'b00, 1'b0); t_exe(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        t_wb(1'b1, 2'b00, 2'b00, 1'b0, 2'b00);

        // lw, 2 MA waits
        set_ir(6'b100011, 6'b000000, 1'b0, 1'b0);
        t_fetch(0); t_dcd(2'b01, 1'b0); t_exe(1'b1, 2'b00, 1'b0, 2'b00, 1'b0);
        t_ma(1'b0, 1'b0, 1'b0); t_ma(1'b0, 1'b0, 1'b0); t_ma(1'b1, 1'b0, 1'b0);
        t_wb(1'b1, 2'b01, 2'b01, 1'b0, 2'b00);

        // beq taken / not taken
        set_ir(6'b000100, 6'b000000, 1'b1, 1'b0);
        t_fetch(0); t_dcd(2'b00, 1'b0); t_exe(1'b0, 2'b01, 1'b0, 2'b01, 1'b1);
        set_ir(6'b000100, 6'b000000, 1'b0, 1'b0);
        t_fetch(0); t_dcd(2'b00, 1'b0); t_exe(1'b0, 2'b01, 1'b0, 2'b01, 1'b0);

        // addi with overflow -> $30 trap, then addi without
        set_ir(6'b001000, 6'b000000, 1'b0, 1'b1);
        t_fetch(0); t_dcd(2'b01, 1'b0); t_exe(1'b1, 2'b00, 1'b1, 2'b00, 1'b0);
        t_wb(1'b1, 2'b11, 2'b11, 1'b0, 2'b00);
        set_ir(6'b001000, 6'b000000, 1'b0, 1'b0);
        t_fetch(0); t_dcd(2'b01, 1'b0); t_exe(1'b1, 2'b00, 1'b1, 2'b00, 1'b0);
        t_wb(1'b1, 2'b00, 2'b01, 1'b0, 2'b00);

        // slt, subu
        set_ir(6'b000000, 6'b101010, 1'b0, 1'b0);
        t_fetch(1); t_dcd(2'b00, 1'b0); t_exe(1'b0, 2'b11, 1'b1, 2'b00, 1'b0);
        t_wb(1'b1, 2'b00, 2'b00, 1'b0, 2'b00);
        set_ir(6'b000000, 6'b100011, 1'b0, 1'b0);
        t_fetch(0); t_dcd(2'b00, 1'b0); t_exe(1'b0, 2'b01, 1'b0, 2'b00, 1'b0);
        t_wb(1'b1, 2'b00, 2'b00, 1'b0, 2'b00);

        // ori, lui, addiu (I-type ALU ops write rt)
        set_ir(6'b001101, 6'b000000, 1'b0, 1'b0);
        t_fetch(0); t_dcd(2'b00, 1'b0); t_exe(1'b1, 2'b10, 1'b0, 2'b00, 1'b0);
        t_wb(1'b1, 2'b00, 2'b01, 1'b0, 2'b00);
        set_ir(6'b001111, 6'b000000, 1'b0, 1'b0);
        t_fetch(0); t_dcd(2'b10, 1'b0); t_exe(1'b1, 2'b00, 1'b0, 2'b00, 1'b0);
        t_wb(1'b1, 2'b00, 2'b01, 1'b0, 2'b00);
        set_ir(6'b001001, 6'b000000, 1'b0, 1'b1);
        t_fetch(0); t_dcd(2'b00, 1'b0); t_exe(1'b1, 2'b00, 1'b0, 2'b00, 1'b0);
        t_wb(1'b1, 2'b00, 2'b01, 1'b0, 2'b00);

        // jal skips EXE; j and jr redirect in EXE
        set_ir(6'b000011, 6'b000000, 1'b0, 1'b0);
        t_fetch(0); t_dcd(2'b00, 1'b0); t_wb(1'b1, 2'b10, 2'b10, 1'b1, 2'b10);
        set_ir(6'b000010, 6'b000000, 1'b0, 1'b0);
        t_fetch(0); t_dcd(2'b00, 1'b0); t_exe(1'b0, 2'b00, 1'b0, 2'b10, 1'b1);
        set_ir(6'b000000, 6'b001000, 1'b0, 1'b0);
        t_fetch(0); t_dcd(2'b00, 1'b0); t_exe(1'b0, 2'b00, 1'b0, 2'b11, 1'b1);

        // sb with immediate ack, lb with one wait
        set_ir(6'b101000, 6'b000000, 1'b0, 1'b0);
        t_fetch(0); t_dcd(2'b01, 1'b0); t_exe(1'b1, 2'b00, 1'b0, 2'b00, 1'b0);
        t_ma(1'b1, 1'b1, 1'b1);
        set_ir(6'b100000, 6'b000000, 1'b0, 1'b0);
        t_fetch(0); t_dcd(2'b01, 1'b0); t_exe(1'b1, 2'b00, 1'b0, 2'b00, 1'b0);
        t_ma(1'b0, 1'b1, 1'b0); t_ma(1'b1, 1'b1, 1'b0);
        t_wb(1'b1, 2'b01, 2'b01, 1'b0, 2'b00);

        // illegal opcode and illegal funct
        set_ir(6'b111111, 6'b000000, 1'b0, 1'b0);
        t_fetch(0); t_dcd(2'b00, 1'b1);
        set_ir(6'b000000, 6'b000000, 1'b0, 1'b0);
        t_fetch(0); t_dcd(2'b00, 1'b1);

        // fetch timeout: 16 waits, one dropped-req cycle ignoring ack, retry
        set_ir(6'b000000, 6'b100001, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            e = f_st(S_FETCH); e.imem_req = 1'b1;
            drive(1'b0, 1'b0, e, "fetch_to_wait");
        end
        drive(1'b1, 1'b0, f_st(S_FETCH), "fetch_drop");
        t_fetch(0); t_dcd(2'b00, 1'b0); t_exe(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        t_wb(1'b1, 2'b00, 2'b00, 1'b0, 2'b00);

        // sw data timeout: 16 MA cycles, no write, sticky bus_err
        set_ir(6'b101011, 6'b000000, 1'b0, 1'b0);
        t_fetch(0); t_dcd(2'b01, 1'b0); t_exe(1'b1, 2'b00, 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 16; i++) t_ma(1'b0, 1'b0, 1'b0);
        exp_bus_err = 1'b1;
        set_ir(6'b000000, 6'b100001, 1'b0, 1'b0);
        t_fetch(2); t_dcd(2'b00, 1'b0); t_exe(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        t_wb(1'b1, 2'b00, 2'b00, 1'b0, 2'b00);

        // reset in the middle of a fetch wait: req drops at once
        e = f_st(S_FETCH); e.imem_req = 1'b1;
        drive(1'b0, 1'b0, e, "pre_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_bus_err = 1'b0;
        exp_q.push_back(f_st(S_IDLE));
        tag_q.push_back("mid_reset");
        drive(1'b0, 1'b0, f_st(S_IDLE), "mid_reset_idle");
        rst = 1'b1;
        e = f_st(S_FETCH); e.imem_req = 1'b1;
        drive(1'b0, 1'b0, e, "post_reset_fetch");

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
